pipe_ctrl: RTL and testbench

Pipeline controller for the five-stage MIPS core. It arbitrates stall requests from the ID, EX and MEM stages into one stall vector for the PC register and the stage pipeline registers (if_id, id_ex, ex_mem, mem_wb). On an exception it issues a flush and the redirect PC, and it masks stall requests from squashed instructions while the pipe refills. It also watches for pathological stalls and, optionally, counts stall and flush events.

---
 rtl/cpu_defines_pkg.sv | 31 +++
 rtl/pipe_stall_wdog.sv | 42 ++++
 rtl/pipe_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defines_pkg.sv
// Shared definitions for the five-stage MIPS core: stall bus layout, exception codes and the
// pipeline-controller state encoding.
package cpu_defines;

  localparam int unsigned StallBusW = 6;

  // Stall bus bit positions, one per pipeline register.
  localparam int unsigned StallPc  = 0;
  localparam int unsigned StallIf  = 1;
  localparam int unsigned StallId  = 2;
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;
  localparam int unsigned StallWb  = 5;

  localparam logic [31:0] ExcEret = 32'h0000_000e;

  localparam logic StallEnable  = 1'b1;
  localparam logic StallDisable = 1'b0;

  typedef logic [StallBusW-1:0] stall_bus_t;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } pipe_ctrl_state_e;

  function automatic logic is_eret(input logic [31:0] excepttype);
    return excepttype == ExcEret;
  endfunction

endpackage

// File: rtl/pipe_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, saturating at WDOG_LIMIT, and raises a
// sticky timeout flag when the limit is reached. Observes only; never alters the stall vector.
module pipe_stall_wdog #(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_active,
  output logic stall_timeout
);

  localparam logic [15:0] Limit = 16'(WDOG_LIMIT);

  logic [15:0] wcnt_q, wcnt_d;
  logic        timeout_q;

  always_comb begin
    wcnt_d = wcnt_q;
    if (!stall_active) begin
      wcnt_d = '0;
    end else if (wcnt_q >= Limit) begin
      wcnt_d = Limit;
    end else begin
      wcnt_d = wcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      if (wcnt_d == Limit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, exception flush/redirect and refill masking.
// Define PIPE_CTRL_PERF_EN to build the stall-cycle and flush event counters.
module pipe_ctrl
  import cpu_defines::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WDOG_LIMIT   = 1024,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_id,
  input  logic                 stallreq_ex,
  input  logic                 stallreq_mem,
  input  logic [31:0]          excepttype_i,
  input  logic [31:0]          cp0_epc_i,
  output logic [StallBusW-1:0] stall_o,
  output logic                 flush_o,
  output logic [31:0]          new_pc_o,
  output logic                 stall_timeout_o,
  output logic [31:0]          stall_cycles_o,
  output logic [15:0]          flush_count_o
);

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);

  pipe_ctrl_state_e state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    stall_o  = '0;
    flush_o  = 1'b0;
    new_pc_o = '0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (excepttype_i != '0) begin
            flush_o  = 1'b1;
            new_pc_o = is_eret(excepttype_i) ? cp0_epc_i : EXC_VECTOR;
            state_d  = StFlush;
            fcnt_d   = FlushInit;
          end else if (stallreq_mem) begin
            stall_o[StallMem:StallPc] = {5{StallEnable}};
          end else if (stallreq_ex) begin
            stall_o[StallEx:StallPc] = {4{StallEnable}};
          end else if (stallreq_id) begin
            stall_o[StallId:StallPc] = {3{StallEnable}};
          end
        end
        StFlush: begin
          // Requests in this window belong to squashed instructions and are ignored.
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  pipe_stall_wdog #(
    .WDOG_LIMIT(WDOG_LIMIT)
  ) u_wdog (
    .clk          (clk),
    .rst          (rst),
    .stall_active (stall_o != '0),
    .stall_timeout(stall_timeout_o)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_o != '0) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (flush_o) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model of the controller's rules.
module tb_pipe_ctrl;

  localparam int unsigned FC = 3;
  localparam int unsigned WL = 4;
  localparam logic [31:0] VEC = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic [31:0] excepttype_i = '0, cp0_epc_i = '0;
  logic [5:0]  stall_o;
  logic        flush_o, stall_timeout_o;
  logic [31:0] new_pc_o, stall_cycles_o;
  logic [15:0] flush_count_o;

  int tests = 0;
  int fails = 0;

  pipe_ctrl #(
    .FLUSH_CYCLES(FC),
    .WDOG_LIMIT  (WL),
    .EXC_VECTOR  (VEC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .excepttype_i   (excepttype_i),
    .cp0_epc_i      (cp0_epc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .stall_timeout_o(stall_timeout_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  always #5 clk = ~clk;

  // Reference model: remaining masked cycles, consecutive stall run, sticky flag, event counts.
  int          m_mask = 0;
  int          m_run = 0;
  logic        m_to = 1'b0;
  logic [31:0] m_sc = '0;
  logic [15:0] m_fc = '0;
  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;
  bit          primed = 0;

  function automatic void model_eval();
    int n;
    e_stall = '0;
    e_flush = 1'b0;
    e_pc    = '0;
    if (!rst && m_mask == 0) begin
      if (excepttype_i != 0) begin
        e_flush = 1'b1;
        e_pc    = (excepttype_i == 32'he) ? cp0_epc_i : VEC;
      end else begin
        // Number of stages held, counted from the PC upward.
        n = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : 0;
        e_stall = 6'((1 << n) - 1);
      end
    end
  endfunction

  function automatic void model_commit();
    if (rst) begin
      m_mask = 0;
      m_run  = 0;
      m_to   = 1'b0;
      m_sc   = '0;
      m_fc   = '0;
    end else begin
      if (m_mask > 0) m_mask = m_mask - 1;
      else if (e_flush) m_mask = FC;
      if (e_stall != 0) begin
        if (m_run < WL) m_run = m_run + 1;
      end else begin
        m_run = 0;
      end
      if (m_run == WL) m_to = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
      if (e_stall != 0) m_sc = m_sc + 32'd1;
      if (e_flush) m_fc = m_fc + 16'd1;
`endif
    end
  endfunction

  task automatic apply(input logic r, input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc);
    @(negedge clk);
    if (primed) model_commit();
    rst          = r;
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    #1;
    model_eval();
    primed = 1;
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 1'b1, 1'b1, 32'h1, 32'h1234);
    tests++;
    if (stall_o !== 6'b0 || flush_o !== 1'b0 || new_pc_o !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: stall=%b flush=%b pc=%h, required 0/0/0", stall_o, flush_o,
               new_pc_o);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall_timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_timeout: got %b, required 0", stall_timeout_o);
    end
    tests++;
    if (stall_cycles_o !== 32'h0 || flush_count_o !== 16'h0) begin
      fails++;
      $display("FAIL reset_counters: got %0d/%0d, required 0/0", stall_cycles_o, flush_count_o);
    end
    tests++;
    if (stall_o !== 6'b0) begin
      fails++;
      $display("FAIL reset_idle_stall: got %b, required 000000", stall_o);
    end
  endtask

  task automatic test_priority();
    do_reset();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall_o !== 6'b001111) begin
      fails++;
      $display("FAIL prio_id_ex: got %b, required 001111", stall_o);
    end
    apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
    tests++;
    if (stall_o !== 6'b011111) begin
      fails++;
      $display("FAIL prio_all: got %b, required 011111", stall_o);
    end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall_o !== 6'b000111 || flush_o !== 1'b0) begin
      fails++;
      $display("FAIL prio_id: got %b flush=%b, required 000111 flush=0", stall_o, flush_o);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall_o !== 6'b000000) begin
      fails++;
      $display("FAIL prio_none: got %b, required 000000", stall_o);
    end
  endtask

  task automatic test_exception();
    do_reset();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h1, 32'h0);
    tests++;
    if (flush_o !== 1'b1 || stall_o !== 6'b0 || new_pc_o !== 32'h20) begin
      fails++;
      $display("FAIL exc_flush: flush=%b stall=%b pc=%h, required 1/000000/00000020", flush_o,
               stall_o, new_pc_o);
    end
    for (int i = 0; i < FC; i++) begin
      apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      tests++;
      if (stall_o !== 6'b0 || flush_o !== 1'b0 || new_pc_o !== 32'h0) begin
        fails++;
        $display("FAIL exc_masked[%0d]: stall=%b flush=%b pc=%h, required 0/0/0", i, stall_o,
                 flush_o, new_pc_o);
      end
    end
    apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall_o !== 6'b001111) begin
      fails++;
      $display("FAIL exc_resume: got %b, required 001111", stall_o);
    end
  endtask

  task automatic test_eret();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'hBFC0_0100);
    tests++;
    if (flush_o !== 1'b1 || new_pc_o !== 32'hBFC0_0100) begin
      fails++;
      $display("FAIL eret_pc: flush=%b pc=%h, required 1/bfc00100", flush_o, new_pc_o);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'hBFC0_0100);
    tests++;
    if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin
      fails++;
      $display("FAIL eret_second_exc: flush=%b pc=%h, required 0/0", flush_o, new_pc_o);
    end
    for (int i = 1; i < FC; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall_timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL wdog_three: got %b, required 0", stall_timeout_o);
    end
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall_o !== 6'b000111 || stall_timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL wdog_fourth: stall=%b timeout=%b, required 000111/0", stall_o,
               stall_timeout_o);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tests++;
      if (stall_timeout_o !== 1'b1) begin
        fails++;
        $display("FAIL wdog_sticky[%0d]: got %b, required 1", i, stall_timeout_o);
      end
    end
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (stall_timeout_o !== 1'b0) begin
      fails++;
      $display("FAIL wdog_cleared: got %b, required 0", stall_timeout_o);
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h0);
    tests++;
    if (stall_o !== 6'b0 || flush_o !== 1'b0 || new_pc_o !== 32'h0) begin
      fails++;
      $display("FAIL rstflush_forced: stall=%b flush=%b pc=%h, required 0/0/0", stall_o,
               flush_o, new_pc_o);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tests++;
    if (stall_o !== 6'b011111) begin
      fails++;
      $display("FAIL rstflush_resume: got %b, required 011111", stall_o);
    end
  endtask

  task automatic test_perf();
    logic [31:0] want_sc;
    logic [15:0] want_fc;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) apply(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
      apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
      for (int i = 0; i < FC; i++) apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    want_sc = 32'd10;
    want_fc = 16'd2;
`else
    want_sc = 32'd0;
    want_fc = 16'd0;
`endif
    tests++;
    if (stall_cycles_o !== want_sc || flush_count_o !== want_fc) begin
      fails++;
      $display("FAIL perf_counts: got %0d/%0d, required %0d/%0d", stall_cycles_o,
               flush_count_o, want_sc, want_fc);
    end
  endtask

  task automatic test_random();
    logic [31:0] exc;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      exc = 32'h0;
      if ($urandom_range(0, 11) == 0) exc = $urandom_range(0, 1) ? 32'he : $urandom;
      apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), exc, $urandom);
      tests++;
      if (stall_o !== e_stall || flush_o !== e_flush || new_pc_o !== e_pc) begin
        fails++;
        $display("FAIL rand_comb[%0d]: stall=%b flush=%b pc=%h, required %b/%b/%h", c, stall_o,
                 flush_o, new_pc_o, e_stall, e_flush, e_pc);
      end
      tests++;
      if (stall_timeout_o !== m_to) begin
        fails++;
        $display("FAIL rand_timeout[%0d]: got %b, required %b", c, stall_timeout_o, m_to);
      end
      tests++;
      if (stall_cycles_o !== m_sc || flush_count_o !== m_fc) begin
        fails++;
        $display("FAIL rand_perf[%0d]: got %0d/%0d, required %0d/%0d", c, stall_cycles_o,
                 flush_count_o, m_sc, m_fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_exception();
    test_eret();
    test_watchdog();
    test_reset_flush();
    test_perf();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
